// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Grants are round-robin. Each result is captured into a one-entry response
// slot per requester and returned over a valid/ready handshake.
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           RST,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_result,
    output logic [2:0]     rsp0_flags,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_result,
    output logic [2:0]     rsp1_flags,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_porta,
    output logic [DW-1:0]  alu_portb,
    input  logic [DW-1:0]  alu_outport,
    input  logic           alu_neg,
    input  logic           alu_zero,
    input  logic           alu_over,

    output logic [15:0]    op_count
);

    // Identity of the most recently accepted requester; the only arbitration state.
    typedef enum logic {
        LAST_0 = 1'b0,
        LAST_1 = 1'b1
    } last_t;

    last_t last_q;
    last_t last_nxt;

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic acc0;
    logic acc1;

    // Response slots: vld_p1 is the slot-full flag and travels with its data.
    logic          vld0_p1;
    logic          vld1_p1;
    logic [DW-1:0] result0_p1;
    logic [DW-1:0] result1_p1;
    logic [2:0]    flags0_p1;
    logic [2:0]    flags1_p1;
    logic [15:0]   count_p1;

    // Round-robin pick: a lone eligible requester wins; on contention the
    // requester that did not win last time is chosen.
    function automatic logic [1:0] pick(input logic e0, input logic e1, input last_t last);
        logic [1:0] g;
        g = 2'b00;
        if (e0 && e1) begin
            g = (last == LAST_1) ? 2'b01 : 2'b10;
        end else if (e0) begin
            g = 2'b01;
        end else if (e1) begin
            g = 2'b10;
        end
        return g;
    endfunction

    // A slot that is being drained this cycle may accept a new operation.
    // Eligibility is suppressed during reset so no request is acknowledged.
    always_comb begin
        elig0 = req0_valid & (~vld0_p1 | rsp0_ready) & ~RST;
        elig1 = req1_valid & (~vld1_p1 | rsp1_ready) & ~RST;
    end

    // Arbitration state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= LAST_1;
        end else begin
            last_q <= last_nxt;
        end
    end

    // Next arbitration state: moves only on an acceptance.
    always_comb begin
        last_nxt = last_q;
        if (acc0) begin
            last_nxt = LAST_0;
        end else if (acc1) begin
            last_nxt = LAST_1;
        end
    end

    // Grant, handshake and ALU input mux; inputs are zero when nothing is granted.
    always_comb begin
        logic [1:0] g;
        g          = pick(elig0, elig1, last_q);
        grant0     = g[0];
        grant1     = g[1];
        req0_ready = grant0;
        req1_ready = grant1;
        acc0       = req0_valid & grant0;
        acc1       = req1_valid & grant1;
        alu_op     = '0;
        alu_porta  = '0;
        alu_portb  = '0;
        if (grant0) begin
            alu_op    = req0_op;
            alu_porta = req0_a;
            alu_portb = req0_b;
        end else if (grant1) begin
            alu_op    = req1_op;
            alu_porta = req1_a;
            alu_portb = req1_b;
        end
    end

    // ---- response stage p1 ----

    // Slot 0: capture on acceptance (overwrites a slot drained this cycle),
    // otherwise empty it once the requester consumes the response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld0_p1    <= 1'b0;
            result0_p1 <= '0;
            flags0_p1  <= '0;
        end else if (acc0) begin
            vld0_p1    <= 1'b1;
            result0_p1 <= alu_outport;
            flags0_p1  <= {alu_over, alu_zero, alu_neg};
        end else if (rsp0_ready) begin
            vld0_p1    <= 1'b0;
        end
    end

    // Slot 1: same behaviour as slot 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld1_p1    <= 1'b0;
            result1_p1 <= '0;
            flags1_p1  <= '0;
        end else if (acc1) begin
            vld1_p1    <= 1'b1;
            result1_p1 <= alu_outport;
            flags1_p1  <= {alu_over, alu_zero, alu_neg};
        end else if (rsp1_ready) begin
            vld1_p1    <= 1'b0;
        end
    end

    // Accepted-operation counter; at most one acceptance per cycle, wraps silently.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_p1 <= '0;
        end else if (acc0 | acc1) begin
            count_p1 <= count_p1 + 16'd1;
        end
    end

    assign rsp0_valid  = vld0_p1;
    assign rsp0_result = result0_p1;
    assign rsp0_flags  = flags0_p1;
    assign rsp1_valid  = vld1_p1;
    assign rsp1_result = result1_p1;
    assign rsp1_flags  = flags1_p1;
    assign op_count    = count_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a response scoreboard for alu_arbiter.
// A small behavioural ALU sits on the alu_* port; expected responses are queued
// as requests are issued and a monitor pops them as responses are consumed.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [3:0]  alu_op;
    logic [31:0] alu_porta, alu_portb, alu_outport;
    logic        alu_neg, alu_zero, alu_over;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    exp_t exp0[$];
    exp_t exp1[$];

    logic [31:0] a0tab [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] r0tab [4] = '{32'd11, 32'd21, 32'd31, 32'd41};
    logic [31:0] a1tab [4] = '{32'd1000, 32'd2000, 32'd3000, 32'd4000};
    logic [31:0] r1tab [4] = '{32'd1005, 32'd2005, 32'd3005, 32'd4005};

    alu_arbiter #(.DW(32), .OPW(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb),
        .alu_outport(alu_outport), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .alu_over(alu_over),
        .op_count(op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU: 0 AND, 1 OR, 2 ADD, 6 SUB.
    always_comb begin
        alu_outport = '0;
        alu_over    = 1'b0;
        case (alu_op)
            4'h0: alu_outport = alu_porta & alu_portb;
            4'h1: alu_outport = alu_porta | alu_portb;
            4'h2: begin
                alu_outport = alu_porta + alu_portb;
                alu_over    = (alu_porta[31] == alu_portb[31]) && (alu_outport[31] != alu_porta[31]);
            end
            4'h6: begin
                alu_outport = alu_porta - alu_portb;
                alu_over    = (alu_porta[31] != alu_portb[31]) && (alu_outport[31] != alu_porta[31]);
            end
            default: alu_outport = '0;
        endcase
        alu_neg  = alu_outport[31];
        alu_zero = (alu_outport == 32'd0);
    end

    function automatic exp_t mk(input logic [31:0] r, input logic [2:0] f);
        exp_t e;
        e.res = r;
        e.fl  = f;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    // Monitor: every response consumed by a requester is compared to the queue head.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (rsp0_valid && rsp0_ready) begin
                if (exp0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp0_unexpected got=0x%0h want=none", rsp0_result);
                end else begin
                    e = exp0.pop_front();
                    chk("sb_rsp0_result", rsp0_result, e.res);
                    chk("sb_rsp0_flags", rsp0_flags, e.fl);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp1_unexpected got=0x%0h want=none", rsp1_result);
                end else begin
                    e = exp1.pop_front();
                    chk("sb_rsp1_result", rsp1_result, e.res);
                    chk("sb_rsp1_flags", rsp1_flags, e.fl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i0;
        int i1;
        RST = 1'b0;
        drive0(1'b0, 4'h0, 32'd0, 32'd0);
        drive1(1'b0, 4'h0, 32'd0, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset state
        #1 RST = 1'b1;
        drive0(1'b1, 4'h2, 32'd9, 32'd0);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        drive0(1'b0, 4'h0, 32'd0, 32'd0);
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_porta", alu_porta, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_flags", rsp1_flags, 0);
        step();
        RST = 1'b0;

        // Basic accept: ADD 5 + 7
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, 4'h2, 32'd5, 32'd7);
        at_neg();
        chk("basic_req0_ready", req0_ready, 1);
        chk("basic_alu_porta", alu_porta, 5);
        exp0.push_back(mk(32'd12, 3'b000));
        step();
        req0_valid = 1'b0;
        at_neg();
        chk("basic_rsp0_valid", rsp0_valid, 1);
        chk("basic_rsp0_result", rsp0_result, 12);
        chk("basic_rsp0_flags", rsp0_flags, 0);
        chk("basic_op_count", op_count, 1);
        step();

        // Single req1 op so that req0 wins the next contention
        drive1(1'b1, 4'h2, 32'd100, 32'd23);
        at_neg();
        chk("single1_req1_ready", req1_ready, 1);
        exp1.push_back(mk(32'd123, 3'b000));
        step();
        req1_valid = 1'b0;
        at_neg();
        step();

        // Contention: grants alternate 0,1,0,1,...
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 8; k++) begin
            req0_valid = (i0 < 4);
            if (i0 < 4) begin req0_op = 4'h2; req0_a = a0tab[i0]; req0_b = 32'd1; end
            req1_valid = (i1 < 4);
            if (i1 < 4) begin req1_op = 4'h2; req1_a = a1tab[i1]; req1_b = 32'd5; end
            at_neg();
            if ((k % 2) == 0) begin
                chk($sformatf("cont_g0_req0_ready_%0d", k), req0_ready, 1);
                chk($sformatf("cont_g0_req1_ready_%0d", k), req1_ready, 0);
                chk($sformatf("cont_g0_porta_%0d", k), alu_porta, a0tab[i0]);
                exp0.push_back(mk(r0tab[i0], 3'b000));
                i0++;
            end else begin
                chk($sformatf("cont_g1_req1_ready_%0d", k), req1_ready, 1);
                chk($sformatf("cont_g1_req0_ready_%0d", k), req0_ready, 0);
                chk($sformatf("cont_g1_porta_%0d", k), alu_porta, a1tab[i1]);
                exp1.push_back(mk(r1tab[i1], 3'b000));
                i1++;
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        at_neg();
        step();

        // Backpressure: slot1 full and not drained blocks only req1
        rsp1_ready = 1'b0;
        drive1(1'b1, 4'h2, 32'd7, 32'd8);
        at_neg();
        chk("bp_fill_req1_ready", req1_ready, 1);
        exp1.push_back(mk(32'd15, 3'b000));
        step();
        drive1(1'b1, 4'h2, 32'd50, 32'd50);
        for (int k = 0; k < 5; k++) begin
            drive0(1'b1, 4'h2, 32'd200 + k, 32'd0);
            at_neg();
            chk($sformatf("bp_req1_ready_%0d", k), req1_ready, 0);
            chk($sformatf("bp_req0_ready_%0d", k), req0_ready, 1);
            chk($sformatf("bp_rsp1_valid_%0d", k), rsp1_valid, 1);
            chk($sformatf("bp_rsp1_result_%0d", k), rsp1_result, 15);
            exp0.push_back(mk(32'd200 + k, 3'b000));
            step();
        end
        rsp1_ready = 1'b1;
        drive0(1'b1, 4'h2, 32'd300, 32'd0);
        at_neg();
        chk("bp_release_req1_ready", req1_ready, 1);
        chk("bp_release_req0_ready", req0_ready, 0);
        exp1.push_back(mk(32'd100, 3'b000));
        step();
        req1_valid = 1'b0;
        at_neg();
        chk("bp_after_req0_ready", req0_ready, 1);
        exp0.push_back(mk(32'd300, 3'b000));
        step();
        req0_valid = 1'b0;
        at_neg();
        step();

        // Flags: SUB 0x80000000 - 1 overflows
        rsp0_ready = 1'b0;
        drive0(1'b1, 4'h6, 32'h8000_0000, 32'd1);
        at_neg();
        chk("flg_req0_ready", req0_ready, 1);
        exp0.push_back(mk(32'h7FFF_FFFF, 3'b100));
        step();
        req0_valid = 1'b0;
        at_neg();
        chk("flg_rsp0_valid", rsp0_valid, 1);
        chk("flg_rsp0_result", rsp0_result, 32'h7FFF_FFFF);
        chk("flg_rsp0_flags", rsp0_flags, 3'b100);
        step();
        rsp0_ready = 1'b1;
        at_neg();
        step();

        // Zero then negative flags on req1, back-to-back (drain and accept together)
        drive1(1'b1, 4'h6, 32'd3, 32'd3);
        at_neg();
        chk("zero_req1_ready", req1_ready, 1);
        exp1.push_back(mk(32'd0, 3'b010));
        step();
        drive1(1'b1, 4'h6, 32'd1, 32'd2);
        at_neg();
        chk("neg_req1_ready", req1_ready, 1);
        exp1.push_back(mk(32'hFFFF_FFFF, 3'b001));
        step();
        req1_valid = 1'b0;
        at_neg();
        step();

        // Asynchronous reset with both slots full
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b1, 4'h2, 32'd1, 32'd1);
        drive1(1'b1, 4'h2, 32'd2, 32'd2);
        at_neg();
        step();
        req0_valid = 1'b0;
        at_neg();
        step();
        req1_valid = 1'b0;
        #2;
        chk("arst_pre_rsp0_valid", rsp0_valid, 1);
        chk("arst_pre_rsp1_valid", rsp1_valid, 1);
        RST = 1'b1;
        #1;
        chk("arst_rsp0_valid", rsp0_valid, 0);
        chk("arst_rsp1_valid", rsp1_valid, 0);
        chk("arst_op_count", op_count, 0);
        chk("arst_rsp1_result", rsp1_result, 0);
        exp0.delete();
        exp1.delete();
        step();
        step();
        RST = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, 4'h2, 32'd11, 32'd0);
        drive1(1'b1, 4'h2, 32'd22, 32'd0);
        at_neg();
        chk("arst_first_req0_ready", req0_ready, 1);
        chk("arst_first_req1_ready", req1_ready, 0);
        chk("arst_first_porta", alu_porta, 11);
        exp0.push_back(mk(32'd11, 3'b000));
        step();
        req0_valid = 1'b0;
        at_neg();
        chk("arst_second_req1_ready", req1_ready, 1);
        chk("arst_count1", op_count, 1);
        exp1.push_back(mk(32'd22, 3'b000));
        step();
        req1_valid = 1'b0;
        at_neg();
        chk("arst_count2", op_count, 2);
        step();

        // Counter wrap: 65535 acceptances, then one more wraps to 0
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp0.delete();
        exp1.delete();
        drive0(1'b1, 4'h2, 32'd1, 32'd1);
        for (int n = 0; n < 65535; n++) begin
            exp0.push_back(mk(32'd2, 3'b000));
            step();
        end
        at_neg();
        chk("wrap_pre_count", op_count, 16'hFFFF);
        chk("wrap_req0_ready", req0_ready, 1);
        exp0.push_back(mk(32'd2, 3'b000));
        step();
        req0_valid = 1'b0;
        at_neg();
        chk("wrap_count", op_count, 0);
        step();
        at_neg();
        step();

        chk("sb_empty0", exp0.size(), 0);
        chk("sb_empty1", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
